// File: rtl/byte_serial_add_sub32_pkg.sv
// Shared definitions for the byte-serial add/subtract unit.
package byte_serial_add_sub32_pkg;

    localparam int unsigned SLICE_W       = 8;
    localparam int unsigned BYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/EightBitKoggeStoneAdder.sv
// 8-bit Kogge-Stone parallel-prefix adder with carry in, carry out and signed overflow.
module EightBitKoggeStoneAdder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic       Cout,
    output logic [7:0] S,
    output logic       overflowFlag
);

    logic [7:0] p0;
    logic [7:0] g0;
    logic [7:0] g1, p1;
    logic [7:0] g2, p2;
    logic [7:0] g3, p3;
    logic [8:0] c;

    // Bit-level propagate/generate; Cin is folded into bit 0's generate.
    always_comb begin
        p0    = A ^ B;
        g0    = A & B;
        g0[0] = (A[0] & B[0]) | (p0[0] & Cin);
    end

    // Prefix levels at distances 1, 2 and 4.
    for (genvar i = 0; i < 8; i++) begin : gen_prefix
        if (i >= 1) begin : gen_l1
            assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
            assign p1[i] = p0[i] & p0[i-1];
        end else begin : gen_l1_pass
            assign g1[i] = g0[i];
            assign p1[i] = p0[i];
        end
        if (i >= 2) begin : gen_l2
            assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
            assign p2[i] = p1[i] & p1[i-2];
        end else begin : gen_l2_pass
            assign g2[i] = g1[i];
            assign p2[i] = p1[i];
        end
        if (i >= 4) begin : gen_l3
            assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
            assign p3[i] = p2[i] & p2[i-4];
        end else begin : gen_l3_pass
            assign g3[i] = g2[i];
            assign p3[i] = p2[i];
        end
    end

    // Group propagates are only needed to build the next level.
    logic unused_p3;
    assign unused_p3 = ^p3;

    assign c            = {g3, Cin};
    assign S            = p0 ^ c[7:0];
    assign Cout         = c[8];
    assign overflowFlag = c[8] ^ c[7];

endmodule

// File: rtl/byte_serial_add_sub32.sv
// Byte-serial 32-bit adder/subtractor: one 8-bit slice per cycle, LSB slice first.
module byte_serial_add_sub32
    import byte_serial_add_sub32_pkg::*;
#(
    parameter int unsigned BYTES = BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [8*BYTES-1:0]     a,
    input  logic [8*BYTES-1:0]     b,
    output logic                   busy,
    output logic                   done,
    output logic [8*BYTES-1:0]     result,
    output logic                   cout,
    output logic                   overflow,
    output logic                   zero
);

    localparam int unsigned W     = SLICE_W * BYTES;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q, b_q, result_q, result_next;
    logic               carry_q, cout_q, ovf_q, zero_q;
    logic               load, last;
    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               c_sl, ovf_sl;

    EightBitKoggeStoneAdder u_slice_add (
        .A            (a_sl),
        .B            (b_sl),
        .Cin          (carry_q),
        .Cout         (c_sl),
        .S            (s_sl),
        .overflowFlag (ovf_sl)
    );

    // Select the current slice and merge its sum into the result word.
    always_comb begin
        a_sl        = a_q[idx_q*SLICE_W +: SLICE_W];
        b_sl        = b_q[idx_q*SLICE_W +: SLICE_W];
        result_next = result_q;
        result_next[idx_q*SLICE_W +: SLICE_W] = s_sl;
        last        = (state_q == StRun) && (idx_q == IDX_W'(BYTES - 1));
    end

    // Next-state logic; a new start is accepted in idle and in the done cycle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Operand latch, slice sequencing and completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            result_q <= result_next;
            carry_q  <= c_sl;
            idx_q    <= idx_q + 1'b1;
            if (last) begin
                cout_q <= c_sl;
                ovf_q  <= ovf_sl;
                zero_q <= (result_next == '0);
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_byte_serial_add_sub32.sv
// Directed self-checking bench for byte_serial_add_sub32.
module tb_byte_serial_add_sub32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, cout, overflow, zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    byte_serial_add_sub32 #(.BYTES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present an operation and return just after the edge that samples it.
    task automatic start_op(input logic s, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen; an exhausted budget counts as a failure.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp_res,
                         input logic exp_c, input logic exp_v, input logic exp_z);
        int n;
        start_op(s, av, bv);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(tag, n);
        check({tag, "_lat"}, n, 32'd4);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_v});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold"}, result, exp_res);
    endtask

    logic        bb_sub [4];
    logic [31:0] bb_a   [4];
    logic [31:0] bb_b   [4];
    logic [31:0] bb_res [4];

    initial begin
        int n;
        int dones;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_flags", {29'd0, cout, overflow, zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_zero", {31'd0, zero}, 32'd0);

        do_op("add0", 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        do_op("addovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op("addwrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op("sub57", 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("subovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op("addmix", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);

        // Start pulse during RUN must be ignored.
        start_op(1'b0, 32'h0000_0010, 32'h0000_0020);
        @(posedge clk);
        #1;
        start = 1'b1;
        sub   = 1'b1;
        a     = 32'hFFFF_FFFF;
        b     = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ign", n);
        check("ign_lat", n, 32'd2);
        check("ign_res", result, 32'h0000_0030);
        @(posedge clk);
        #1;
        check("ign_idle", {30'd0, busy, done}, 32'd0);

        // Reset mid-RUN aborts without a done pulse.
        start_op(1'b0, 32'h0101_0101, 32'h0202_0202);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_state", {30'd0, busy, done}, 32'd0);
        check("abort_res", result, 32'd0);
        check("abort_flags", {29'd0, cout, overflow, zero}, 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("abort_nodone", dones, 32'd0);
        do_op("after_abort", 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        // Back-to-back operations with start held high.
        bb_sub[0] = 1'b0; bb_a[0] = 32'h0000_0001; bb_b[0] = 32'h0000_0002; bb_res[0] = 32'h0000_0003;
        bb_sub[1] = 1'b1; bb_a[1] = 32'h0000_0100; bb_b[1] = 32'h0000_0001; bb_res[1] = 32'h0000_00FF;
        bb_sub[2] = 1'b0; bb_a[2] = 32'h0000_FF00; bb_b[2] = 32'h0000_0100; bb_res[2] = 32'h0001_0000;
        bb_sub[3] = 1'b0; bb_a[3] = 32'hDEAD_BEEF; bb_b[3] = 32'h1111_1111; bb_res[3] = 32'h0;
        @(negedge clk);
        start = 1'b1;
        sub   = bb_sub[0];
        a     = bb_a[0];
        b     = bb_b[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sub = bb_sub[k+1];
            a   = bb_a[k+1];
            b   = bb_b[k+1];
            wait_done($sformatf("bb%0d", k), n);
            check($sformatf("bb%0d_lat", k), n, 32'd4);
            check($sformatf("bb%0d_res", k), result, bb_res[k]);
            if (k == 2) start = 1'b0;
            @(posedge clk);
            #1;
            if (k < 2) check($sformatf("bb%0d_next", k), {30'd0, busy, done}, 32'd2);
            else       check("bb_end", {30'd0, busy, done}, 32'd0);
        end
        check("bb_cout", {31'd0, cout}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
